// File: rtl/vend_pkg.sv
// Shared definitions for the two-station brew scheduler: FSM encoding,
// station indices and the width of the per-station pending counters.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BREW  = 3'd2,
        GAP   = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic ST0 = 1'b0;
    localparam logic ST1 = 1'b1;

    // Counters stay 3 bits wide for every legal queue depth (1..7).
    function automatic int pend_width(input int max_pending);
        return (max_pending <= 7) ? 3 : $clog2(max_pending + 1);
    endfunction

    localparam int PEND_W = pend_width(7);

endpackage

// File: rtl/vend_order_queue.sv
// Saturating count of paid-but-unserved orders for one station, with a
// registered one-cycle drop pulse when an order arrives to a full queue.
module vend_order_queue
    import vend_pkg::*;
#(
    parameter int MAX_PENDING = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              drop
);

    localparam logic [PEND_W-1:0] MAX_CNT = PEND_W'(MAX_PENDING);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (inc && !dec) begin
                // A grant in the same cycle frees a slot, so only refuse when none is leaving.
                if (count == MAX_CNT) begin
                    drop <= 1'b1;
                end else begin
                    count <= count + PEND_W'(1);
                end
            end else if (dec && !inc) begin
                if (count != '0) begin
                    count <= count - PEND_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vend_brew_scheduler.sv
// Shares one brewer between two vending stations: per-station order queues,
// round-robin grant, start/done handshake, post-brew gap and brew watchdog.
module vend_brew_scheduler
    import vend_pkg::*;
#(
    parameter int MAX_PENDING  = 3,
    parameter int BREW_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic              brew_done,
    output logic              brew_start,
    output logic              brew_sel,
    output logic              busy,
    output logic [1:0]        cup_ready,
    output logic [1:0]        drop,
    output logic              fault,
    output logic [PEND_W-1:0] pending0,
    output logic [PEND_W-1:0] pending1
);

    localparam int TW = $clog2(BREW_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BREW_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

    state_t        state, state_next;
    logic          last_served;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;
    logic          grant;
    logic          grant_fire;
    logic          dec0, dec1;
    logic          drop0, drop1;

    vend_order_queue #(.MAX_PENDING(MAX_PENDING)) u_queue0 (
        .clk   (clk),
        .reset (reset),
        .inc   (req[0]),
        .dec   (dec0),
        .count (pending0),
        .drop  (drop0)
    );

    vend_order_queue #(.MAX_PENDING(MAX_PENDING)) u_queue1 (
        .clk   (clk),
        .reset (reset),
        .inc   (req[1]),
        .dec   (dec1),
        .count (pending1),
        .drop  (drop1)
    );

    assign drop = {drop1, drop0};

    // Arbiter looks only at registered counts, so a same-cycle req waits a cycle.
    always_comb begin
        grant = ST0;
        if (pending0 != '0 && pending1 != '0) begin
            grant = ~last_served;
        end else if (pending1 != '0) begin
            grant = ST1;
        end
        grant_fire = (state == IDLE) && (pending0 != '0 || pending1 != '0);
        dec0 = grant_fire && (grant == ST0);
        dec1 = grant_fire && (grant == ST1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (grant_fire) state_next = START;
            START: state_next = BREW;
            BREW: begin
                if (brew_done) begin
                    state_next = GAP;
                end else if (timer == TIMER_LAST) begin
                    state_next = FAULT;
                end
            end
            GAP:   if (gap_cnt == '0) state_next = IDLE;
            FAULT: state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    assign brew_start = (state == START);
    assign busy       = (state != IDLE);
    assign fault      = (state == FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            brew_sel    <= ST0;
            last_served <= ST1;
            timer       <= '0;
            gap_cnt     <= '0;
            cup_ready   <= 2'b00;
        end else begin
            cup_ready <= 2'b00;
            if (grant_fire) begin
                brew_sel    <= grant;
                last_served <= grant;
            end
            case (state)
                START: timer <= '0;
                BREW: begin
                    timer <= timer + TW'(1);
                    if (brew_done) begin
                        cup_ready <= (brew_sel == ST1) ? 2'b10 : 2'b01;
                        gap_cnt   <= GAP_LOAD;
                    end
                end
                GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
                default: ;
            endcase
        end
    end

endmodule
